// File: rtl/heart.sv
`default_nettype none
// ============================================================================
// Module   : heart
// Brief    : 16x16 player-heart sprite ROM. Maps a sprite-local (x,y) pixel
//            coordinate to a registered 12-bit RGB colour, one pixel per
//            clock with one cycle of latency.
// Options  : HEART_OUTLINE_EN - when defined, mask pixels on the shape's
//            border (a 4-neighbour outside the mask or the grid) are drawn
//            in EDGE_RGB instead of FG_RGB.
// Revision : 1.0 - initial release
// ============================================================================
module heart #(
  parameter logic [11:0] FG_RGB   = 12'hF00,
  parameter logic [11:0] BG_RGB   = 12'h000,
  parameter logic [11:0] EDGE_RGB = 12'hFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  x,
  input  logic [3:0]  y,
  output logic [11:0] rgb_reg
);

  // Row bitmap of the heart; bit 15 is column 0 (leftmost).
  function automatic logic [15:0] row_bits(input logic [3:0] row);
    logic [15:0] bits;
    case (row)
      4'd0:    bits = 16'h0000;
      4'd1:    bits = 16'h0000;
      4'd2:    bits = 16'h3C3C;
      4'd3:    bits = 16'h7E7E;
      4'd4:    bits = 16'hFFFF;
      4'd5:    bits = 16'hFFFF;
      4'd6:    bits = 16'hFFFF;
      4'd7:    bits = 16'h7FFE;
      4'd8:    bits = 16'h3FFC;
      4'd9:    bits = 16'h1FF8;
      4'd10:   bits = 16'h0FF0;
      4'd11:   bits = 16'h07E0;
      4'd12:   bits = 16'h03C0;
      4'd13:   bits = 16'h0180;
      default: bits = 16'h0000;
    endcase
    return bits;
  endfunction

  logic [15:0] w_row_cur;
  logic [3:0]  w_idx;
  logic        w_in_mask;
  logic        w_edge;
  logic [11:0] w_rgb;

`ifdef HEART_OUTLINE_EN
  logic [15:0] w_row_up;
  logic [15:0] w_row_dn;
  logic [3:0]  w_idx_l;
  logic [3:0]  w_idx_r;
`endif

  // Decode the mask bit (and, optionally, the outline flag) for this pixel.
  always_comb begin
    w_row_cur = row_bits(y);
    // Column x lives at bit (15 - x), which is simply the bitwise inverse.
    w_idx     = ~x;
    w_in_mask = w_row_cur[w_idx];
    w_edge    = 1'b0;
`ifdef HEART_OUTLINE_EN
    // Neighbour lookups may wrap; the grid-boundary terms mask those cases.
    w_row_up  = row_bits(y - 4'd1);
    w_row_dn  = row_bits(y + 4'd1);
    w_idx_l   = w_idx + 4'd1;
    w_idx_r   = w_idx - 4'd1;
    w_edge    = w_in_mask &&
                ((x == 4'd0) || (x == 4'd15) || (y == 4'd0) || (y == 4'd15) ||
                 !w_row_cur[w_idx_l] || !w_row_cur[w_idx_r] ||
                 !w_row_up[w_idx]    || !w_row_dn[w_idx]);
`endif
  end

  // Select the colour from the mask and outline flags.
  always_comb begin
    w_rgb = BG_RGB;
    if (w_in_mask) begin
      w_rgb = w_edge ? EDGE_RGB : FG_RGB;
    end
  end

  // Output register; asynchronously cleared to black.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_reg <= 12'h000;
    end else begin
      rgb_reg <= w_rgb;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_heart.sv
`default_nettype none
// ============================================================================
// Module   : tb_heart
// Brief    : Self-checking bench for the heart sprite ROM. Expected colours
//            come from a picture-level model: the heart is held as a 2-D
//            bitmap and the outline is found by looking at grid neighbours.
// Revision : 1.0 - initial release
// ============================================================================
module tb_heart;

  logic        clk;
  logic        reset_n;
  logic [3:0]  x;
  logic [3:0]  y;
  logic [11:0] rgb_reg;

  int checks;
  int errors;

  heart dut (
    .clk     (clk),
    .reset_n (reset_n),
    .x       (x),
    .y       (y),
    .rgb_reg (rgb_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Picture of the heart, one word per row, leftmost column in the MSB.
  logic [15:0] pic [16];
  initial begin
    pic[0]  = 16'h0000; pic[1]  = 16'h0000; pic[2]  = 16'h3C3C; pic[3]  = 16'h7E7E;
    pic[4]  = 16'hFFFF; pic[5]  = 16'hFFFF; pic[6]  = 16'hFFFF; pic[7]  = 16'h7FFE;
    pic[8]  = 16'h3FFC; pic[9]  = 16'h1FF8; pic[10] = 16'h0FF0; pic[11] = 16'h07E0;
    pic[12] = 16'h03C0; pic[13] = 16'h0180; pic[14] = 16'h0000; pic[15] = 16'h0000;
  end

  function automatic bit filled(int px, int py);
    logic [15:0] r;
    if (px < 0 || px > 15 || py < 0 || py > 15) return 1'b0;
    r = pic[py];
    return r[15 - px];
  endfunction

  function automatic logic [11:0] model(int px, int py);
    if (!filled(px, py)) return 12'h000;
`ifdef HEART_OUTLINE_EN
    if (!filled(px - 1, py) || !filled(px + 1, py) ||
        !filled(px, py - 1) || !filled(px, py + 1)) return 12'hFFF;
`endif
    return 12'hF00;
  endfunction

  task automatic check(string name, logic [11:0] act, logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one pixel ahead of the next rising edge.
  task automatic drive(int px, int py);
    @(negedge clk);
    x = 4'(px);
    y = 4'(py);
  endtask

  typedef struct {
    int          px;
    int          py;
    logic [11:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[8];
  logic [11:0] obs [16][16];
  int q_x[$];
  int q_y[$];

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b1;
    x       = 4'd7;
    y       = 4'd7;

`ifdef HEART_OUTLINE_EN
    vecs[0] = '{0, 4, 12'hFFF, "edge_0_4"};
    vecs[1] = '{7, 13, 12'hFFF, "tip_7_13"};
`else
    vecs[0] = '{0, 4, 12'hF00, "edge_0_4"};
    vecs[1] = '{7, 13, 12'hF00, "tip_7_13"};
`endif
    vecs[2] = '{7, 7, 12'hF00, "interior_7_7"};
    vecs[3] = '{0, 0, 12'h000, "bg_0_0"};
    vecs[4] = '{15, 15, 12'h000, "bg_15_15"};
    vecs[5] = '{0, 7, 12'h000, "bg_0_7"};
    vecs[6] = '{8, 13, model(8, 13), "tip_8_13"};
    vecs[7] = '{7, 14, 12'h000, "below_tip_7_14"};

    // Let the register settle on a real pixel, then reset asynchronously.
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_7_7", rgb_reg, 12'hF00);
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_async", rgb_reg, 12'h000);
    @(posedge clk);
    #1;
    check("reset_held", rgb_reg, 12'h000);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release", rgb_reg, 12'hF00);

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].px, vecs[i].py);
      @(posedge clk);
      #1;
      check(vecs[i].name, rgb_reg, vecs[i].exp);
    end

    // Back-to-back stream: each output belongs to the pixel of the prior edge.
    drive(0, 4);
    @(posedge clk); #1;
    check("stream_0_4", rgb_reg, model(0, 4));
    drive(7, 7);
    check("stream_hold", rgb_reg, model(0, 4));
    @(posedge clk); #1;
    check("stream_7_7", rgb_reg, model(7, 7));
    drive(0, 0);
    @(posedge clk); #1;
    check("stream_0_0", rgb_reg, model(0, 0));

    // Exhaustive sweep, streamed one pixel per cycle.
    for (int py = 0; py < 16; py++) begin
      for (int px = 0; px < 16; px++) begin
        drive(px, py);
        @(posedge clk); #1;
        obs[py][px] = rgb_reg;
        check("sweep", rgb_reg, model(px, py));
      end
    end
    for (int py = 0; py < 16; py++) begin
      for (int px = 0; px < 8; px++) begin
        check("mirror", obs[py][px], obs[py][15 - px]);
      end
    end

    // Random streaming against the model via a pending-pixel queue.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (q_x.size() != 0) begin
        check("random", rgb_reg, model(q_x.pop_front(), q_y.pop_front()));
      end
      x = 4'($urandom_range(15, 0));
      y = 4'($urandom_range(15, 0));
      q_x.push_back(int'(x));
      q_y.push_back(int'(y));
      if ($urandom_range(19, 0) == 0) begin
        // Occasional mid-frame reset: output must drop at once.
        #2;
        reset_n = 1'b0;
        #1;
        check("random_reset", rgb_reg, 12'h000);
        #1;
        reset_n = 1'b1;
      end
    end
    @(posedge clk); #1;
    check("random_last", rgb_reg, model(q_x.pop_front(), q_y.pop_front()));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
